rca_pipe_arbiter: RTL

//  Shares one 2-stage pipelined adder (rippleCarryAdder_pipeline_2, NBITS wide, result 1 clk after operand sample) among NREQ requesters.

---
 rtl/rca_pkg.sv | 16 +
 rtl/rca_rsp_fifo.sv | 49 ++++
 rtl/rippleCarryAdder_pipeline_2.sv | 33 +++
 rtl/rca_pipe_arbiter.sv | 107 ++++++++++
 4 files changed

// File: rtl/rca_pkg.sv
// Shared widths and helpers for the round-robin pipelined-adder arbiter.
package rca_pkg;

  localparam int DEF_NBITS   = 16;
  localparam int DEF_ADD_LAT = 1;

  function automatic int id_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  // A response entry is packed as {id, sum}
  function automatic int rsp_w(input int nreq, input int nbits);
    return id_w(nreq) + nbits;
  endfunction

endpackage

// File: rtl/rca_rsp_fifo.sv
// Show-ahead response FIFO; push and pop may coincide at any fill level.
module rca_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_pop;

  assign do_pop = pop && (count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (push && !do_pop)      count <= count + 1'b1;
      else if (!push && do_pop) count <= count - 1'b1;
    end
  end

  // Empty FIFO presents zeros so the head never shows stale data
  assign head = (count != '0) ? mem[rd_ptr] : '0;

  always @(posedge clk) begin
    if (rst_n && push && !do_pop) assert (count != CW'(DEPTH));
  end

endmodule

// File: rtl/rippleCarryAdder_pipeline_2.sv
// Two-stage adder: low half and its carry are registered, high half completes after the register.
module rippleCarryAdder_pipeline_2 #(
  parameter int NBITS = 16
) (
  input  logic             clk,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  input  logic             cin,
  output logic [NBITS-1:0] sum
);

  localparam int H  = NBITS / 2;
  localparam int HH = NBITS - H;

  logic [H:0]    lo_full;
  logic [H-1:0]  lo_r;
  logic          c_r;
  logic [HH-1:0] a_hi_r;
  logic [HH-1:0] b_hi_r;

  assign lo_full = {1'b0, a[H-1:0]} + {1'b0, b[H-1:0]} + {{H{1'b0}}, cin};

  // No reset: downstream qualifies results with its own valid bits
  always_ff @(posedge clk) begin
    lo_r   <= lo_full[H-1:0];
    c_r    <= lo_full[H];
    a_hi_r <= a[NBITS-1:H];
    b_hi_r <= b[NBITS-1:H];
  end

  assign sum = {a_hi_r + b_hi_r + {{(HH-1){1'b0}}, c_r}, lo_r};

endmodule

// File: rtl/rca_pipe_arbiter.sv
// Round-robin sharing of one pipelined adder among NREQ requesters, with
// credit-based flow control into a tagged, backpressurable response FIFO.
module rca_pipe_arbiter
  import rca_pkg::*;
#(
  parameter  int NREQ       = 4,
  parameter  int NBITS      = DEF_NBITS,
  parameter  int ADD_LAT    = DEF_ADD_LAT,
  parameter  int FIFO_DEPTH = 4,
  localparam int ID_W       = id_w(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*NBITS-1:0] req_a,
  input  logic [NREQ*NBITS-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [NBITS-1:0]      rsp_sum,
  output logic                  busy
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int RW = rsp_w(NREQ, NBITS);

  logic [ID_W-1:0]    ptr;
  logic               credit;
  logic               gnt_any;
  logic [ID_W-1:0]    gnt_idx;
  int                 scan;
  logic [NBITS-1:0]   add_a;
  logic [NBITS-1:0]   add_b;
  logic               add_cin;
  logic [NBITS-1:0]   add_sum;
  logic [ADD_LAT-1:0] tag_valid;
  logic [ID_W-1:0]    tag_id [ADD_LAT];
  logic [CW-1:0]      fifo_count;
  logic [RW-1:0]      fifo_head;

  // In-flight ops hold a reserved slot; a pop in this same cycle is not credited
  assign credit = rst_n && ((int'(fifo_count) + $countones(tag_valid)) < FIFO_DEPTH);

  always_comb begin
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    req_ready = '0;
    scan      = 0;
    if (credit) begin
      for (int k = 0; k < NREQ; k++) begin
        scan = int'(ptr) + k;
        if (scan >= NREQ) scan = scan - NREQ;
        if (!gnt_any && req_valid[ID_W'(scan)]) begin
          gnt_any = 1'b1;
          gnt_idx = ID_W'(scan);
        end
      end
    end
    if (gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  assign add_a   = gnt_any ? req_a[gnt_idx*NBITS +: NBITS] : '0;
  assign add_b   = gnt_any ? req_b[gnt_idx*NBITS +: NBITS] : '0;
  assign add_cin = gnt_any ? req_cin[gnt_idx] : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      tag_valid <= '0;
      for (int k = 0; k < ADD_LAT; k++) tag_id[k] <= '0;
    end else begin
      if (gnt_any) ptr <= (int'(gnt_idx) + 1 >= NREQ) ? '0 : gnt_idx + 1'b1;
      tag_valid[0] <= gnt_any;
      tag_id[0]    <= gnt_idx;
      for (int k = 1; k < ADD_LAT; k++) begin
        tag_valid[k] <= tag_valid[k-1];
        tag_id[k]    <= tag_id[k-1];
      end
    end
  end

  rippleCarryAdder_pipeline_2 #(.NBITS(NBITS)) u_adder (
    .clk (clk),
    .a   (add_a),
    .b   (add_b),
    .cin (add_cin),
    .sum (add_sum)
  );

  rca_rsp_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(RW), .CW(CW)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tag_valid[ADD_LAT-1]),
    .push_data ({tag_id[ADD_LAT-1], add_sum}),
    .pop       (rsp_ready),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign rsp_valid = (fifo_count != '0);
  assign rsp_id    = fifo_head[NBITS +: ID_W];
  assign rsp_sum   = fifo_head[NBITS-1:0];
  assign busy      = (|tag_valid) || (fifo_count != '0);

endmodule
